// File: rtl/alu_pipe.sv
// Pipelined integer ALU feeding the CDB with a globally stalled, in-order result pipeline.
// Optional multiplier ops enabled by defining ALU_PIPE_MUL_EN.
module alu_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned PRF_LEN = 6,
    parameter int unsigned ROB_LEN = 5
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     in_func,
    input  logic [XLEN-1:0]                in_opa,
    input  logic [XLEN-1:0]                in_opb,
    input  logic [PRF_LEN-1:0]             in_prf_idx,
    input  logic [ROB_LEN-1:0]             in_rob_idx,
    input  logic [XLEN-1:0]                in_pc,
    input  logic                           flush,
    input  logic                           cdb_grant,
    output logic                           out_valid,
    output logic [XLEN-1:0]                out_value,
    output logic [PRF_LEN-1:0]             out_prf_idx,
    output logic [ROB_LEN-1:0]             out_rob_idx,
    output logic [XLEN-1:0]                out_pc,
    output logic [$clog2(STAGES+1)-1:0]    occupancy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned OCW = $clog2(STAGES+1);
    localparam logic [XLEN-1:0] DEFAULT_RESULT = XLEN'(32'hfacebeec);

    typedef enum logic [3:0] {
        F_ADD    = 4'd0,
        F_SUB    = 4'd1,
        F_SLT    = 4'd2,
        F_SLTU   = 4'd3,
        F_AND    = 4'd4,
        F_OR     = 4'd5,
        F_XOR    = 4'd6,
        F_SLL    = 4'd7,
        F_SRL    = 4'd8,
        F_SRA    = 4'd9,
        F_MUL    = 4'd10,
        F_MULH   = 4'd11,
        F_MULHSU = 4'd12,
        F_MULHU  = 4'd13
    } alu_func_e;

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf;
        logic [ROB_LEN-1:0] rob;
        logic [XLEN-1:0]    pc;
    } entry_t;

    alu_func_e         func;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   result;
    logic              advance;
    logic              accept;
    logic              pop;
    entry_t            issue_entry;
    entry_t            data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [OCW-1:0]    occ_q;

    assign func  = alu_func_e'(in_func);
    assign shamt = in_opb[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
    logic [2*XLEN-1:0] prod_ss;
    logic [2*XLEN-1:0] prod_su;
    logic [2*XLEN-1:0] prod_uu;

    // Operands extended to 2*XLEN so one unsigned multiply yields each signedness variant.
    assign prod_ss = {{XLEN{in_opa[XLEN-1]}}, in_opa} * {{XLEN{in_opb[XLEN-1]}}, in_opb};
    assign prod_su = {{XLEN{in_opa[XLEN-1]}}, in_opa} * {{XLEN{1'b0}}, in_opb};
    assign prod_uu = {{XLEN{1'b0}}, in_opa} * {{XLEN{1'b0}}, in_opb};
`endif

    always_comb begin
        result = DEFAULT_RESULT;
        case (func)
            F_ADD:    result = in_opa + in_opb;
            F_SUB:    result = in_opa - in_opb;
            F_SLT:    result = {{(XLEN-1){1'b0}}, $signed(in_opa) < $signed(in_opb)};
            F_SLTU:   result = {{(XLEN-1){1'b0}}, in_opa < in_opb};
            F_AND:    result = in_opa & in_opb;
            F_OR:     result = in_opa | in_opb;
            F_XOR:    result = in_opa ^ in_opb;
            F_SLL:    result = in_opa << shamt;
            F_SRL:    result = in_opa >> shamt;
            F_SRA:    result = $signed(in_opa) >>> shamt;
`ifdef ALU_PIPE_MUL_EN
            F_MUL:    result = prod_ss[XLEN-1:0];
            F_MULH:   result = prod_ss[2*XLEN-1:XLEN];
            F_MULHSU: result = prod_su[2*XLEN-1:XLEN];
            F_MULHU:  result = prod_uu[2*XLEN-1:XLEN];
`endif
            default:  result = DEFAULT_RESULT;
        endcase
    end

    assign advance  = !out_valid || cdb_grant;
    assign in_ready = advance;
    assign accept   = in_valid && advance && !flush;
    assign pop      = out_valid && cdb_grant;

    assign issue_entry = '{value: result, prf: in_prf_idx, rob: in_rob_idx, pc: in_pc};

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q[0] <= accept;
            for (int unsigned i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (advance) begin
            data_q[0] <= issue_entry;
            for (int unsigned i = 1; i < STAGES; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            occ_q <= '0;
        end else if (accept && !pop) begin
            occ_q <= occ_q + OCW'(1);
        end else if (pop && !accept) begin
            occ_q <= occ_q - OCW'(1);
        end
    end

    assign occupancy   = occ_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_value   = data_q[STAGES-1].value;
    assign out_prf_idx = data_q[STAGES-1].prf;
    assign out_rob_idx = data_q[STAGES-1].rob;
    assign out_pc      = data_q[STAGES-1].pc;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard testbench for alu_pipe (XLEN=32, STAGES=2); honours ALU_PIPE_MUL_EN for expectations.
module tb_alu_pipe;

    localparam bit [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_SLT = 4'd2, F_SLTU = 4'd3;
    localparam bit [3:0] F_SLL = 4'd7, F_SRL = 4'd8, F_SRA = 4'd9;
    localparam bit [3:0] F_MUL = 4'd10, F_MULH = 4'd11, F_MULHU = 4'd13, F_BAD = 4'd15;

    typedef struct {
        logic [31:0] value;
        logic [5:0]  prf;
        logic [4:0]  rob;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_func = '0;
    logic [31:0] in_opa = '0;
    logic [31:0] in_opb = '0;
    logic [5:0]  in_prf_idx = '0;
    logic [4:0]  in_rob_idx = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        cdb_grant = 1'b0;
    logic        out_valid;
    logic [31:0] out_value;
    logic [5:0]  out_prf_idx;
    logic [4:0]  out_rob_idx;
    logic [31:0] out_pc;
    logic [1:0]  occupancy;

    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    alu_pipe #(.XLEN(32), .STAGES(2), .PRF_LEN(6), .ROB_LEN(5)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_func(in_func), .in_opa(in_opa), .in_opb(in_opb), .in_prf_idx(in_prf_idx),
        .in_rob_idx(in_rob_idx), .in_pc(in_pc), .flush(flush), .cdb_grant(cdb_grant),
        .out_valid(out_valid), .out_value(out_value), .out_prf_idx(out_prf_idx),
        .out_rob_idx(out_rob_idx), .out_pc(out_pc), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  s;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        s = b[4:0];
        p = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            4'd3: return {31'b0, a < b};
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return a << s;
            4'd8: return a >> s;
            4'd9: return (a >> s) | (a[31] ? ~(32'hffffffff >> s) : 32'h0);
`ifdef ALU_PIPE_MUL_EN
            4'd10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            4'd11: begin p = sa * sb; return p[63:32]; end
            4'd12: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            4'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
`endif
            default: return 32'hfacebeec;
        endcase
    endfunction

    // Scoreboard: pop/compare on broadcast, push on acceptance, discard on flush/reset.
    always @(negedge clock) begin
        if (mon_en) begin
            if (!reset_n || flush) begin
                q.delete();
            end else begin
                vectors++;
                if (int'(occupancy) !== q.size()) begin
                    miscompares++;
                    $display("FAIL occupancy: got %0d, expected %0d at %0t", occupancy, q.size(), $time);
                end
                vectors++;
                if (in_ready !== (!out_valid || cdb_grant)) begin
                    miscompares++;
                    $display("FAIL in_ready: got %b, expected %b at %0t", in_ready, !out_valid || cdb_grant, $time);
                end
                if (out_valid === 1'b1 && cdb_grant) begin
                    vectors++;
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL spurious_output: got value %h with nothing in flight at %0t", out_value, $time);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        if ({out_value, out_prf_idx, out_rob_idx, out_pc} !== {e.value, e.prf, e.rob, e.pc}) begin
                            miscompares++;
                            $display("FAIL result: got %h/%h/%h/%h, expected %h/%h/%h/%h at %0t",
                                     out_value, out_prf_idx, out_rob_idx, out_pc,
                                     e.value, e.prf, e.rob, e.pc, $time);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back('{value: model(in_func, in_opa, in_opb), prf: in_prf_idx, rob: in_rob_idx, pc: in_pc});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input int tag);
        in_valid   = 1'b1;
        in_func    = f;
        in_opa     = a;
        in_opb     = b;
        in_prf_idx = 6'(tag);
        in_rob_idx = 5'(tag + 3);
        in_pc      = 32'h1000 + 32'(tag) * 4;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        vectors++;
        if ({out_valid, occupancy, in_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b occ=%0d ready=%b, expected 0/0/1", out_valid, occupancy, in_ready);
        end
        tick();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        cdb_grant = 1'b1;
        set_op(F_ADD, 32'd5, 32'd7, 9);
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got out_valid=%b one cycle after issue, expected 0", out_valid);
        end
        tick();
        @(negedge clock);
        vectors++;
        if ({out_valid, out_value, out_prf_idx, out_rob_idx, out_pc} !== {1'b1, 32'd12, 6'd9, 5'd12, 32'h1024}) begin
            miscompares++;
            $display("FAIL latency_result: got %b/%h/%h/%h/%h, expected 1/0000000c/09/0c/00001024",
                     out_valid, out_value, out_prf_idx, out_rob_idx, out_pc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cdb_grant = 1'b0;
        set_op(F_ADD, 32'd1, 32'd0, 1);
        tick();
        set_op(F_ADD, 32'd2, 32'd0, 2);
        tick();
        set_op(F_ADD, 32'd3, 32'd0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if ({in_ready, occupancy, out_valid, out_value} !== {1'b0, 2'd2, 1'b1, 32'd1}) begin
                miscompares++;
                $display("FAIL stall_hold: got ready=%b occ=%0d valid=%b value=%h, expected 0/2/1/00000001",
                         in_ready, occupancy, out_valid, out_value);
            end
            tick();
        end
        cdb_grant = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            vectors++;
            if ({out_valid, out_value} !== {1'b1, 32'(i)}) begin
                miscompares++;
                $display("FAIL drain_order: got valid=%b value=%h, expected 1/%h", out_valid, out_value, 32'(i));
            end
            tick();
            in_valid = 1'b0;
        end
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got out_valid=%b, expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{F_SRA,  32'h80000000, 32'h00000021, 32'hc0000000});
        v.push_back('{F_SLT,  32'hffffffff, 32'h00000001, 32'h00000001});
        v.push_back('{F_SLTU, 32'hffffffff, 32'h00000001, 32'h00000000});
        v.push_back('{F_ADD,  32'hffffffff, 32'h00000001, 32'h00000000});
        v.push_back('{F_SUB,  32'h00000000, 32'h00000001, 32'hffffffff});
        v.push_back('{F_SLL,  32'h00000001, 32'h0000003f, 32'h80000000});
        v.push_back('{F_SRL,  32'h80000000, 32'h00000020, 32'h80000000});
        v.push_back('{F_BAD,  32'h12345678, 32'h9abcdef0, 32'hfacebeec});
`ifdef ALU_PIPE_MUL_EN
        v.push_back('{F_MULH,  32'hffffffff, 32'hffffffff, 32'h00000000});
        v.push_back('{F_MULHU, 32'hffffffff, 32'hffffffff, 32'hfffffffe});
        v.push_back('{F_MUL,   32'hfffffffd, 32'h00000007, 32'hffffffeb});
`else
        v.push_back('{F_MUL,   32'h00000005, 32'h00000007, 32'hfacebeec});
        v.push_back('{F_MULHU, 32'hffffffff, 32'hffffffff, 32'hfacebeec});
`endif
        cdb_grant = 1'b1;
        foreach (v[k]) begin
            bit seen;
            set_op(v[k].f, v[k].a, v[k].b, k + 20);
            tick();
            in_valid = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clock);
                if (out_valid === 1'b1) begin
                    seen = 1'b1;
                    vectors++;
                    if (out_value !== v[k].e) begin
                        miscompares++;
                        $display("FAIL directed_%0d func=%0d: got %h, expected %h", k, v[k].f, out_value, v[k].e);
                    end
                end
                tick();
            end
            if (!seen) begin
                vectors++;
                miscompares++;
                $display("FAIL directed_%0d timeout: got no out_valid, expected a result", k);
            end
        end
    endtask

    task automatic test_flush();
        int spurious;
        cdb_grant = 1'b0;
        set_op(F_ADD, 32'd10, 32'd0, 4);
        tick();
        set_op(F_ADD, 32'd11, 32'd0, 5);
        tick();
        set_op(F_ADD, 32'd99, 32'd0, 6);
        flush     = 1'b1;
        cdb_grant = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if ({out_valid, occupancy} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_clear: got valid=%b occ=%0d, expected 0/0", out_valid, occupancy);
        end
        spurious = 0;
        repeat (6) begin
            tick();
            @(negedge clock);
            if (out_valid === 1'b1) spurious++;
        end
        vectors++;
        if (spurious !== 0) begin
            miscompares++;
            $display("FAIL flush_ghost: got %0d outputs after flush, expected 0", spurious);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_func    = 4'($urandom_range(0, 15));
            in_opa     = $urandom();
            in_opb     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            in_prf_idx = 6'($urandom());
            in_rob_idx = 5'($urandom());
            in_pc      = $urandom();
            cdb_grant  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 63) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        cdb_grant = 1'b1;
        repeat (6) tick();
        @(negedge clock);
        vectors++;
        if (q.size() !== 0) begin
            miscompares++;
            $display("FAIL random_drain: got %0d results still owed, expected 0", q.size());
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        int spurious;
        cdb_grant = 1'b0;
        set_op(F_ADD, 32'd40, 32'd1, 7);
        tick();
        set_op(F_ADD, 32'd41, 32'd1, 8);
        tick();
        set_op(F_ADD, 32'd42, 32'd1, 9);
        reset_n   = 1'b0;
        cdb_grant = 1'b1;
        tick();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if ({out_valid, occupancy, in_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_inflight: got valid=%b occ=%0d ready=%b, expected 0/0/1", out_valid, occupancy, in_ready);
        end
        spurious = 0;
        repeat (6) begin
            tick();
            @(negedge clock);
            if (out_valid === 1'b1) spurious++;
        end
        vectors++;
        if (spurious !== 0) begin
            miscompares++;
            $display("FAIL reset_ghost: got %0d outputs after reset, expected 0", spurious);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_directed();
        test_flush();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (SHALL be a power of two, >= 8).
REQ-002 Parameter STAGES, default 2, pipeline depth in cycles (SHALL be >= 1).
REQ-003 Parameter PRF_LEN, default 6, physical-register tag width.
REQ-004 Parameter ROB_LEN, default 5, ROB index width.
REQ-005 clock  in  1  single clock, all state updates on rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 in_valid  in  1  issue request carrying a valid operation.
REQ-008 in_ready  out  1  unit can accept an issue this cycle.
REQ-009 in_func  in  ALU_FUNC  operation select.
REQ-010 in_opa, in_opb  in  XLEN  operands.
REQ-011 in_prf_idx  in  PRF_LEN; in_rob_idx  in  ROB_LEN; in_pc  in  XLEN  tags carried with the operation.
REQ-012 flush  in  1  squash all in-flight operations (branch mispredict).
REQ-013 cdb_grant  in  1  CDB accepts the current output this cycle.
REQ-014 out_valid  out  1  result available for broadcast.
REQ-015 out_value  out  XLEN; out_prf_idx  out  PRF_LEN; out_rob_idx  out  ROB_LEN; out_pc  out  XLEN  result and tags.
REQ-016 occupancy  out  $clog2(STAGES+1)  number of valid in-flight entries.

Function
REQ-017 Issue SHALL be accepted when in_valid && in_ready && !flush.
REQ-018 advance = !out_valid || cdb_grant; in_ready SHALL equal advance; all stages SHALL shift together only on advance (global stall, no bubble collapse).
REQ-019 Latency: an accepted operation SHALL appear at out_valid exactly STAGES cycles after acceptance with no stall; each stall cycle adds one.
REQ-020 Results SHALL leave in issue order; the output and its tags SHALL hold stable while out_valid && !cdb_grant.
REQ-021 ADD/SUB/AND/OR/XOR SHALL be modulo 2^XLEN; SLT signed compare, SLTU unsigned, result zero-extended 0/1.
REQ-022 SLL/SRL/SRA SHALL use in_opb[$clog2(XLEN)-1:0] as shift amount; SRA sign-fills.
REQ-023 Unsupported in_func SHALL produce XLEN'hfacebeec (truncated/zero-extended to XLEN).
REQ-024 flush SHALL clear every stage valid and occupancy at the next edge, dominating cdb_grant and same-cycle issue; out_valid SHALL be 0 the cycle after flush.
REQ-025 occupancy SHALL increment on accept, decrement on (out_valid && cdb_grant), be unchanged when both occur, and never exceed STAGES.
REQ-026 When full (occupancy==STAGES) and cdb_grant asserted, a new issue SHALL be accepted the same cycle.
REQ-027 cdb_grant while out_valid==0 SHALL have no effect.

Reset
REQ-028 reset_n low at an edge SHALL clear all stage valids, out_valid=0, occupancy=0, in_ready=1 next cycle; data/tag registers need not reset.
REQ-029 Reset SHALL dominate flush, issue and cdb_grant; an operation in flight at reset SHALL never emerge.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN defined: MUL (low XLEN of signed product), MULH (high signed x signed), MULHSU (high signed x unsigned), MULHU (high unsigned x unsigned) SHALL be supported at the same STAGES latency.
REQ-031 ALU_PIPE_MUL_EN undefined: no multiplier SHALL be synthesised; MUL* funcs SHALL return the REQ-023 default value with normal timing.

Verification
REQ-032 XLEN=32,STAGES=2: issue ADD 5+7 at cycle 0, cdb_grant held 1 -> out_valid at cycle 2, out_value=12, tags match.
REQ-033 Issue 3 back-to-back ops, cdb_grant=0 -> in_ready drops when occupancy=2, output holds first result; raise grant -> results 1,2,3 in order, one per cycle.
REQ-034 SRA 0x80000000 by opb=0x21 -> 0xC0000000; SLT 0xFFFFFFFF<1 -> 1; SLTU same -> 0.
REQ-035 Pipeline full, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, flushed-cycle issue never emerges.
REQ-036 ALU_PIPE_MUL_EN defined: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000, MULHU -> 0xFFFFFFFE; undefined: MUL -> 0xfacebeec.
REQ-037 reset_n=0 with two ops in flight -> next cycle out_valid=0, occupancy=0, in_ready=1; no result appears after reset release.
